// File: rtl/nl_pkg.sv
// Shared opcodes, FSM state type and slot indices for the RSA <-> NonLinear dispatcher.
package nl_pkg;

   localparam logic [1:0] OP_PREDICT = 2'd0;
   localparam logic [1:0] OP_NEWLM   = 2'd1;
   localparam logic [1:0] OP_UPDATE  = 2'd2;
   localparam logic [1:0] OP_RSVD    = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   localparam int unsigned N_OPND    = 6;
   localparam int unsigned OPND_XK   = 0;
   localparam int unsigned OPND_YK   = 1;
   localparam int unsigned OPND_LKX  = 2;
   localparam int unsigned OPND_LKY  = 3;
   localparam int unsigned OPND_VLR  = 4;
   localparam int unsigned OPND_RK   = 5;

   localparam int unsigned N_ANG     = 3;
   localparam int unsigned ANG_XITA  = 0;
   localparam int unsigned ANG_ALPHA = 1;
   localparam int unsigned ANG_PHI   = 2;

endpackage

// File: rtl/nl_req_fifo.sv
// Synchronous request FIFO; pointers carry an extra wrap bit to tell full from empty.
module nl_req_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             sys_rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_wr, do_rd;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      do_wr    = wr_en & ~full;
      do_rd    = rd_en & ~empty;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
   end

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is not reset: entries are only read while the pointers say they are valid.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/nl_dispatch.sv
// Queued request/response dispatcher between the RSA array and the NonLinear unit:
// saturating angle conversion, one-hot init issue, done timeout and val/rdy responses.
module nl_dispatch
   import nl_pkg::*;
#(
   parameter int unsigned DW      = 32,
   parameter int unsigned ANG_W   = 17,
   parameter int unsigned ANG_HI  = 19,
   parameter int unsigned RES_NUM = 6,
   parameter int unsigned QDEPTH  = 4,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic                    clk,
   input  logic                    sys_rst,
   input  logic                    req_val,
   output logic                    req_rdy,
   input  logic [1:0]              req_op,
   input  logic [N_OPND*DW-1:0]    req_opnd,
   input  logic [N_ANG*DW-1:0]     req_ang,
   output logic [2:0]              nl_init,
   output logic [N_OPND*DW-1:0]    nl_opnd,
   output logic [N_ANG*ANG_W-1:0]  nl_ang,
   input  logic [2:0]              nl_done,
   input  logic [RES_NUM*DW-1:0]   nl_result,
   output logic                    rsp_val,
   input  logic                    rsp_rdy,
   output logic [1:0]              rsp_op,
   output logic [RES_NUM*DW-1:0]   rsp_data,
   output logic                    rsp_err,
   output logic                    rsp_sat,
   output logic                    busy
);

   localparam int unsigned SHIFT  = ANG_HI - (ANG_W - 2);
   localparam int unsigned OPND_W = N_OPND * DW;
   localparam int unsigned ANGS_W = N_ANG * ANG_W;
   localparam int unsigned ENT_W  = 2 + OPND_W + ANGS_W + 1;
   localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic signed [DW-1:0] ANG_MAX  = DW'((1 << (ANG_W - 1)) - 1);
   localparam logic signed [DW-1:0] ANG_MIN  = -ANG_MAX - 1;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2:0]            nl_init_q, nl_init_d;
   logic [OPND_W-1:0]     nl_opnd_q, nl_opnd_d;
   logic [ANGS_W-1:0]     nl_ang_q, nl_ang_d;
   logic [1:0]            cur_op_q, cur_op_d;
   logic [RES_NUM*DW-1:0] rsp_data_q, rsp_data_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  rsp_sat_q, rsp_sat_d;
   logic                  rsp_val_q, rsp_val_d;
   logic                  rdy_en_q, rdy_en_d;

   logic signed [DW-1:0]  ang_src, ang_shr;
   logic [ANGS_W-1:0]     ang_cv;
   logic [N_ANG-1:0]      slot_sat;
   logic [ENT_W-1:0]      wr_entry, rd_entry;
   logic                  push, pop, fifo_full, fifo_empty, done_hit;
   logic [1:0]            rd_op;
   logic [OPND_W-1:0]     rd_opnd;
   logic [ANGS_W-1:0]     rd_ang;
   logic                  rd_sat;

   always_comb begin
      ang_cv   = '0;
      slot_sat = '0;
      ang_src  = '0;
      ang_shr  = '0;
      for (int unsigned i = 0; i < N_ANG; i++) begin
         ang_src = req_ang[i*DW +: DW];
         ang_shr = ang_src >>> SHIFT;
         if (ang_shr > ANG_MAX) begin
            ang_cv[i*ANG_W +: ANG_W] = ANG_MAX[ANG_W-1:0];
            slot_sat[i]              = 1'b1;
         end else if (ang_shr < ANG_MIN) begin
            ang_cv[i*ANG_W +: ANG_W] = ANG_MIN[ANG_W-1:0];
            slot_sat[i]              = 1'b1;
         end else begin
            ang_cv[i*ANG_W +: ANG_W] = ang_shr[ANG_W-1:0];
         end
      end
   end

   // rdy_en_q keeps req_rdy low until the first edge after reset is released.
   assign req_rdy  = rdy_en_q & ~fifo_full;
   assign push     = req_val & req_rdy;
   assign wr_entry = {req_op, req_opnd, ang_cv, |slot_sat};
   assign rd_op    = rd_entry[ENT_W-1 -: 2];
   assign rd_opnd  = rd_entry[ENT_W-3 -: OPND_W];
   assign rd_ang   = rd_entry[ANGS_W:1];
   assign rd_sat   = rd_entry[0];

   nl_req_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk     (clk),
      .sys_rst (sys_rst),
      .wr_en   (push),
      .wr_data (wr_entry),
      .rd_en   (pop),
      .rd_data (rd_entry),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      case (cur_op_q)
         OP_PREDICT: done_hit = nl_done[0];
         OP_NEWLM:   done_hit = nl_done[1];
         OP_UPDATE:  done_hit = nl_done[2];
         default:    done_hit = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      nl_init_d  = '0;
      nl_opnd_d  = nl_opnd_q;
      nl_ang_d   = nl_ang_q;
      cur_op_d   = cur_op_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      rsp_sat_d  = rsp_sat_q;
      rdy_en_d   = 1'b1;
      pop        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               cur_op_d  = rd_op;
               rsp_sat_d = rd_sat;
               if (rd_op == OP_RSVD) begin
                  rsp_data_d = '0;
                  rsp_err_d  = 1'b1;
                  state_d    = S_RESP;
               end else begin
                  nl_opnd_d = rd_opnd;
                  nl_ang_d  = rd_ang;
                  nl_init_d = 3'b001 << rd_op;
                  cnt_d     = '0;
                  state_d   = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (done_hit) begin
               rsp_data_d = nl_result;
               rsp_err_d  = 1'b0;
               state_d    = S_RESP;
            end else if (TIMEOUT > 0 && cnt_q == CNT_LAST) begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = S_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESP: begin
            if (rsp_rdy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      rsp_val_d = (state_d == S_RESP);
   end

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         nl_init_q  <= '0;
         nl_opnd_q  <= '0;
         nl_ang_q   <= '0;
         cur_op_q   <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         rsp_sat_q  <= 1'b0;
         rsp_val_q  <= 1'b0;
         rdy_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         nl_init_q  <= nl_init_d;
         nl_opnd_q  <= nl_opnd_d;
         nl_ang_q   <= nl_ang_d;
         cur_op_q   <= cur_op_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         rsp_sat_q  <= rsp_sat_d;
         rsp_val_q  <= rsp_val_d;
         rdy_en_q   <= rdy_en_d;
      end
   end

   assign nl_init  = nl_init_q;
   assign nl_opnd  = nl_opnd_q;
   assign nl_ang   = nl_ang_q;
   assign rsp_val  = rsp_val_q;
   assign rsp_op   = cur_op_q;
   assign rsp_data = rsp_data_q;
   assign rsp_err  = rsp_err_q;
   assign rsp_sat  = rsp_sat_q;
   assign busy     = (state_q != S_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_nl_dispatch.sv
// Directed bench for nl_dispatch: angle saturation, issue/response timing, timeout,
// reserved op, FIFO back-pressure and reset in the middle of a request.
module tb_nl_dispatch;

   localparam int DW    = 32;
   localparam int ANG_W = 17;

   logic                 clk = 1'b0;
   logic                 sys_rst;
   logic                 req_val;
   logic                 req_rdy;
   logic [1:0]           req_op;
   logic [6*DW-1:0]      req_opnd;
   logic [3*DW-1:0]      req_ang;
   logic [2:0]           nl_init;
   logic [6*DW-1:0]      nl_opnd;
   logic [3*ANG_W-1:0]   nl_ang;
   logic [2:0]           nl_done;
   logic [6*DW-1:0]      nl_result;
   logic                 rsp_val;
   logic                 rsp_rdy;
   logic [1:0]           rsp_op;
   logic [6*DW-1:0]      rsp_data;
   logic                 rsp_err;
   logic                 rsp_sat;
   logic                 busy;

   int n_chk = 0;
   int n_err = 0;

   nl_dispatch #(
      .DW      (DW),
      .ANG_W   (ANG_W),
      .ANG_HI  (19),
      .RES_NUM (6),
      .QDEPTH  (4),
      .TIMEOUT (8)
   ) dut (
      .clk       (clk),
      .sys_rst   (sys_rst),
      .req_val   (req_val),
      .req_rdy   (req_rdy),
      .req_op    (req_op),
      .req_opnd  (req_opnd),
      .req_ang   (req_ang),
      .nl_init   (nl_init),
      .nl_opnd   (nl_opnd),
      .nl_ang    (nl_ang),
      .nl_done   (nl_done),
      .nl_result (nl_result),
      .rsp_val   (rsp_val),
      .rsp_rdy   (rsp_rdy),
      .rsp_op    (rsp_op),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .rsp_sat   (rsp_sat),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [6*DW-1:0] mk6(input logic [31:0] base, input int seed);
      logic [6*DW-1:0] v;
      for (int s = 0; s < 6; s++) v[s*DW +: DW] = base + 32'(seed * 16 + s);
      return v;
   endfunction

   task automatic send(input logic [1:0] op, input logic [6*DW-1:0] opnd,
                       input logic [3*DW-1:0] ang, input string tag);
      int n = 0;
      req_val  = 1'b1;
      req_op   = op;
      req_opnd = opnd;
      req_ang  = ang;
      while (!req_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk({tag, "_accept_timeout"}, 0, 1);
      @(negedge clk);
      req_val = 1'b0;
   endtask

   task automatic wait_init(output int n);
      n = 0;
      while (nl_init == 3'b000 && n < 50) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (!rsp_val && n < 50) begin
         @(negedge clk);
         n++;
      end
   endtask

   // One normal request: accept, issue, optional wrong-bit/idle done cycles, then completion.
   task automatic run_one(input string tag, input logic [1:0] op, input logic [6*DW-1:0] opnd,
                          input logic [3*DW-1:0] ang, input logic [3*ANG_W-1:0] exp_ang,
                          input logic exp_sat, input int dly, input bit wrong,
                          input logic [6*DW-1:0] res);
      int n;
      logic [2:0] hit;
      hit = 3'b001 << op;
      send(op, opnd, ang, tag);
      wait_init(n);
      chk({tag, "_init_lat"}, n, 1);
      chk({tag, "_init"}, nl_init, hit);
      chk({tag, "_ang"}, nl_ang, exp_ang);
      chk({tag, "_opnd"}, nl_opnd, opnd);
      nl_result = res;
      for (int k = 0; k < dly; k++) begin
         nl_done = wrong ? (3'b111 & ~hit) : 3'b000;
         @(negedge clk);
         chk({tag, "_val_early"}, rsp_val, 0);
         chk({tag, "_init_once"}, nl_init, 0);
      end
      nl_done = hit;
      @(negedge clk);
      nl_done   = 3'b000;
      nl_result = ~res;
      chk({tag, "_val"}, rsp_val, 1);
      chk({tag, "_op"}, rsp_op, op);
      chk({tag, "_data"}, rsp_data, res);
      chk({tag, "_err"}, rsp_err, 0);
      chk({tag, "_sat"}, rsp_sat, exp_sat);
      @(negedge clk);
      chk({tag, "_val_drop"}, rsp_val, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no_finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      logic [1:0] bp_ops [5];
      bp_ops = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

      sys_rst   = 1'b1;
      req_val   = 1'b0;
      req_op    = '0;
      req_opnd  = '0;
      req_ang   = '0;
      nl_done   = '0;
      nl_result = '0;
      rsp_rdy   = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_req_rdy", req_rdy, 0);
      chk("rst_ctrl", {nl_init, rsp_val, rsp_err, rsp_sat, rsp_op, busy}, 0);
      chk("rst_data", rsp_data, 0);
      sys_rst = 1'b0;
      @(negedge clk);
      chk("post_rst_rdy", req_rdy, 1);

      run_one("pred", 2'd0, mk6(32'hA000_0000, 1), {32'h0, 32'h0001_0000, 32'h0},
              {17'h00000, 17'h01000, 17'h00000}, 1'b0, 2, 1'b0, mk6(32'hC000_0000, 1));

      // Reserved op: straight to an error response, no init pulse.
      send(2'd3, mk6(32'hA000_0000, 2), '0, "rsvd");
      chk("rsvd_no_init0", nl_init, 0);
      wait_rsp(n);
      chk("rsvd_lat", n, 1);
      chk("rsvd_no_init1", nl_init, 0);
      chk("rsvd_err", rsp_err, 1);
      chk("rsvd_data", rsp_data, 0);
      chk("rsvd_op", rsp_op, 3);
      @(negedge clk);
      chk("rsvd_val_drop", rsp_val, 0);

      run_one("sat_hi", 2'd1, mk6(32'hA000_0000, 3), {32'hFFF0_0000, 32'h0010_0000, 32'h0},
              {17'h10000, 17'h0FFFF, 17'h00000}, 1'b1, 0, 1'b0, mk6(32'hC000_0000, 3));
      run_one("min_ok", 2'd2, mk6(32'hA000_0000, 4), {32'hFFF0_0000, 32'hFFFF_FFF0, 32'h0000_0123},
              {17'h10000, 17'h1FFFF, 17'h00012}, 1'b0, 2, 1'b1, mk6(32'hC000_0000, 4));
      run_one("sat_lo", 2'd0, mk6(32'hA000_0000, 5), {32'h0, 32'h000F_FFF0, 32'hFFE0_0000},
              {17'h00000, 17'h0FFFF, 17'h10000}, 1'b1, 1, 1'b0, mk6(32'hC000_0000, 5));

      rsp_rdy = 1'b0;
      send(2'd0, mk6(32'hA000_0000, 6), '0, "tmo");
      wait_init(n);
      chk("tmo_init_lat", n, 1);
      wait_rsp(n);
      chk("tmo_lat", n, 8);
      chk("tmo_err", rsp_err, 1);
      chk("tmo_data", rsp_data, 0);
      nl_done = 3'b001;
      @(negedge clk);
      nl_done = 3'b000;
      chk("tmo_hold_val", rsp_val, 1);
      chk("tmo_hold", {rsp_err, rsp_data}, {1'b1, 192'h0});
      rsp_rdy = 1'b1;
      @(negedge clk);
      chk("tmo_val_drop", rsp_val, 0);
      nl_done = 3'b001;
      @(negedge clk);
      nl_done = 3'b000;
      chk("tmo_late_done", {rsp_val, nl_init, busy}, 0);

      rsp_rdy = 1'b0;
      for (int i = 0; i < 5; i++) send(bp_ops[i], mk6(32'hB000_0000, i), '0, "bp");
      chk("bp_full_rdy", req_rdy, 0);
      chk("bp_busy", busy, 1);
      nl_done   = 3'b001;
      nl_result = mk6(32'hD000_0000, 0);
      @(negedge clk);
      nl_done = 3'b000;
      chk("bp_val0", rsp_val, 1);
      chk("bp_op0", rsp_op, 0);
      chk("bp_data0", rsp_data, mk6(32'hD000_0000, 0));
      repeat (2) @(negedge clk);
      chk("bp_held_val", rsp_val, 1);
      chk("bp_held_rdy", req_rdy, 0);
      rsp_rdy = 1'b1;
      @(negedge clk);
      chk("bp_hs_val", rsp_val, 0);
      chk("bp_hs_rdy", req_rdy, 0);
      @(negedge clk);
      chk("bp_freed_rdy", req_rdy, 1);
      for (int i = 1; i < 5; i++) begin
         wait_init(n);
         chk($sformatf("bp_issue_lat%0d", i), n, (i == 1) ? 0 : 1);
         chk($sformatf("bp_init%0d", i), nl_init, 3'b001 << bp_ops[i]);
         chk($sformatf("bp_opnd%0d", i), nl_opnd, mk6(32'hB000_0000, i));
         nl_done   = 3'b001 << bp_ops[i];
         nl_result = mk6(32'hD000_0000, i);
         @(negedge clk);
         nl_done = 3'b000;
         chk($sformatf("bp_val%0d", i), rsp_val, 1);
         chk($sformatf("bp_op%0d", i), rsp_op, bp_ops[i]);
         chk($sformatf("bp_data%0d", i), rsp_data, mk6(32'hD000_0000, i));
         @(negedge clk);
      end
      chk("bp_idle", busy, 0);

      send(2'd2, mk6(32'hA000_0000, 9), {32'h0, 32'h0001_0000, 32'h0}, "mid");
      wait_init(n);
      @(negedge clk);
      sys_rst = 1'b1;
      nl_done = 3'b100;
      @(negedge clk);
      chk("mid_rst_ctrl", {nl_init, rsp_val, rsp_err, rsp_sat, rsp_op, req_rdy, busy}, 0);
      chk("mid_rst_opnd", nl_opnd, 0);
      chk("mid_rst_ang", nl_ang, 0);
      chk("mid_rst_data", rsp_data, 0);
      @(negedge clk);
      sys_rst = 1'b0;
      @(negedge clk);
      chk("mid_no_stale", {rsp_val, nl_init, busy}, 0);
      chk("mid_rdy", req_rdy, 1);
      nl_done = 3'b000;
      run_one("fresh", 2'd2, mk6(32'hA000_0000, 10), {32'hFFF0_0000, 32'h0001_0000, 32'h0},
              {17'h10000, 17'h01000, 17'h00000}, 1'b0, 1, 1'b0, mk6(32'hC000_0000, 10));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/nl_dispatch.md
# nl_dispatch

Parametrised dispatcher between the RSA systolic array and the NonLinear unit. It replaces the fixed point-to-point wiring of init/done pulses and six result wires with a queued request/response channel. Requests carry an opcode, scalar operands and angles. Angles are converted to the NonLinear angle width with saturation, issued one at a time as one-hot init pulses, and guarded by a done timeout. Results return to the RSA over a val/rdy handshake.

## Interface
Parameters:
- DW, 32: scalar/result word width (signed fixed point).
- ANG_W, 17: NonLinear angle width (signed).
- ANG_HI, 19: source bit that maps to output bit ANG_W-2; shift amount is ANG_HI-(ANG_W-2).
- RES_NUM, 6: result words per response.
- QDEPTH, 4: request FIFO depth, power of two, at least 2.
- TIMEOUT, 1023: maximum WAIT cycles before an error response; 0 disables the timeout.

Ports:
- clk, in, 1: single clock, rising edge.
- sys_rst, in, 1: synchronous, active-high reset.
- req_val, in, 1; req_rdy, out, 1: request handshake. Transfer occurs when both are high at a clock edge.
- req_op, in, 2: 0 predict, 1 newlm, 2 update, 3 reserved.
- req_opnd, in, 6*DW: slots 0 xk, 1 yk, 2 lkx, 3 lky, 4 vlr, 5 rk.
- req_ang, in, 3*DW: slots 0 xita, 1 alpha, 2 phi.
- nl_init, out, 3: one-hot start pulse, bit index equals op.
- nl_opnd, out, 6*DW; nl_ang, out, 3*ANG_W: registered operands, held stable from the init cycle until the next issue.
- nl_done, in, 3: completion flags from the NonLinear unit.
- nl_result, in, RES_NUM*DW: NonLinear results.
- rsp_val, out, 1; rsp_rdy, in, 1: response handshake.
- rsp_op, out, 2: opcode of the response.
- rsp_data, out, RES_NUM*DW: response data.
- rsp_err, out, 1: set on timeout or reserved op.
- rsp_sat, out, 1: set when any angle of this request saturated.
- busy, out, 1: high when FSM is not IDLE or the FIFO is non-empty.

## Operation
- Enqueue:
  - req_rdy = !fifo_full.
  - On transfer, store op, opnd, converted angles and a sat flag.
  - Angle conversion happens combinationally before the FIFO write.
- Angle conversion per slot: a = src >>> (ANG_HI-ANG_W+2), arithmetic shift.
  - Clamp a to [-2^(ANG_W-1), 2^(ANG_W-1)-1].
  - sat is set if clamping occurred.
  - rsp_sat is the OR of the three slot sat flags.
- FSM states: IDLE, WAIT, RESP.
  - IDLE, FIFO non-empty, op≠3: pop the FIFO. Load nl_opnd/nl_ang, set nl_init[op], clear the timeout counter, go to WAIT.
  - IDLE, FIFO non-empty, op=3: pop the FIFO. Set rsp_data=0 and rsp_err=1, go to RESP. No init pulse is issued.
  - WAIT, nl_done[op]=1: capture nl_result into rsp_data, rsp_err=0, go to RESP. Other nl_done bits are ignored.
  - WAIT, counter = TIMEOUT-1 and no done (TIMEOUT>0): rsp_data=0, rsp_err=1, go to RESP.
  - WAIT, done and timeout in the same cycle: done wins.
  - RESP: rsp_val=1, outputs held stable. On rsp_val&rsp_rdy go to IDLE.
- nl_init is high only during the first WAIT cycle.
- nl_done received in IDLE or RESP is ignored.
- FIFO full with a simultaneous pop: req_rdy stays low that cycle. The freed slot is visible the next cycle.
- Reset: FIFO empties, FSM returns to IDLE, and all outputs go to 0 (req_rdy goes to 1 in the cycle after reset deasserts). A reset mid-WAIT drops the request and returns no response.

## Timing
- Accept at edge E0 with FIFO empty and FSM in IDLE: the FSM leaves IDLE at E1, and nl_init is high in cycle E1–E2.
- nl_done is sampled in every WAIT cycle, including the init cycle. Done seen at edge En sets rsp_val high from En onward.
- Minimum request-to-response latency is 2 edges after the accept edge.
- After a response handshake at edge Er, the next request issues at Er+1. At least one IDLE cycle separates issues.
- Timeout response: rsp_val rises exactly TIMEOUT cycles after nl_init rises.
- Reserved op: rsp_val rises 1 edge after the pop.

## Structure
- Package nl_pkg contains:
  - opcode constants OP_PREDICT=0, OP_NEWLM=1, OP_UPDATE=2, OP_RSVD=3;
  - the FSM state enum;
  - operand and angle slot index constants.
- Sub-module nl_req_fifo: synchronous FIFO, QDEPTH deep, width 2+6*DW+3*ANG_W+1. It has full/empty flags and pointers with a wrap bit.

## Test plan
- Predict, alpha=32'h0001_0000, done returned 3 cycles after init, rsp_rdy=1 → nl_init=3'b001, nl_ang[alpha]=17'h01000, rsp_val high, rsp_data equals nl_result, err=0, sat=0.
- Angle boundaries: alpha=32'h0010_0000 → 17'h0FFFF, sat=1. phi=32'hFFF0_0000 → 17'h10000, sat=0. xita=32'hFFE0_0000 → 17'h10000, sat=1.
- Back-pressure: 5 back-to-back requests, QDEPTH=4, one in WAIT and rsp_rdy=0 → req_rdy drops after the FIFO fills. All 5 responses arrive in order with the correct rsp_op.
- Timeout: TIMEOUT=8, nl_done never asserted → rsp_val rises 8 cycles after nl_init, err=1, data=0. A later nl_done is ignored.
- Reserved op=3 → no nl_init pulse, rsp_err=1 after 1 cycle. A wrong-bit done (op=update, nl_done=3'b001) is ignored until nl_done=3'b100 arrives.
- Reset mid-WAIT, then a fresh update request → no stale response, outputs are 0 during reset, and the new request completes normally.
